// File: rtl/pi_error_sequencer_if.sv
// Sample-side handshake and integrator-side strobes of the PI error sequencer.
// The master drives samples and collects ek/strobes; the slave is the sequencer.
interface pi_error_sequencer_if #(
  parameter int N = 18
);
  logic signed [N-1:0] ref_in;
  logic signed [N-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                hold;
  logic signed [N-1:0] ek;
  logic                en1;
  logic                en2;
  logic                busy;
  logic                sat_flag;

  modport master (
    output ref_in, sample_in, sample_valid, hold,
    input  sample_ready, ek, en1, en2, busy, sat_flag
  );

  modport slave (
    input  ref_in, sample_in, sample_valid, hold,
    output sample_ready, ek, en1, en2, busy, sat_flag
  );
endinterface

// File: rtl/pi_error_sequencer.sv
// Producer side of the integral-term interface: captures ref-sample as a saturated ek,
// holds it while the integrator pipeline settles, and issues one en1/en2 pair per sample.
module pi_error_sequencer #(
  parameter int N   = 18,
  parameter int LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pi_error_sequencer_if.slave   bus
);
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, HOLD, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [N-1:0] ek_q, ek_d;
  logic                sat_q, sat_d;
  logic                en1_q, en1_d;
  logic                en2_q, en2_d;

  logic signed [N:0]   diff;
  logic                ovf;
  logic [N-1:0]        sat_val;
  logic                accept;

  // One extra bit makes the subtraction exact; the top two bits disagree only on overflow.
  always_comb begin
    diff    = {bus.ref_in[N-1], bus.ref_in} - {bus.sample_in[N-1], bus.sample_in};
    ovf     = diff[N] ^ diff[N-1];
    sat_val = diff[N-1:0];
    if (ovf) sat_val = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end

  assign accept = (state_q == IDLE) && !bus.hold && bus.sample_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ek_d    = ek_q;
    sat_d   = sat_q;
    en1_d   = 1'b0;
    en2_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        ek_d    = sat_val;
        sat_d   = ovf;
        en1_d   = 1'b1;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        // en2 is registered so it lands exactly in the COMMIT cycle.
        if (cnt_q == CW'(LAT - 1)) begin
          state_d = COMMIT;
          en2_d   = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ek_q    <= '0;
      sat_q   <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ek_q    <= ek_d;
      sat_q   <= sat_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
    end
  end

  assign bus.sample_ready = (state_q == IDLE) && !bus.hold;
  assign bus.ek           = ek_q;
  assign bus.sat_flag     = sat_q;
  assign bus.en1          = en1_q;
  assign bus.en2          = en2_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_pi_error_sequencer.sv
// Directed bench for pi_error_sequencer: scoreboard of expected ek/sat_flag popped on en1,
// plus a small behavioural integrator to check en2 commit timing.
module tb_pi_error_sequencer;
  localparam int N    = 18;
  localparam int LAT  = 3;
  localparam int KI   = 7;
  localparam int MAXV = (1 << (N - 1)) - 1;
  localparam int MINV = -(1 << (N - 1));

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pi_error_sequencer_if #(.N(N)) ifc();
  pi_error_sequencer #(.N(N), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  int total = 0;
  int bad   = 0;
  int en2_cnt = 0;
  int exp_ek_q[$];
  int exp_sat_q[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_ek(input int r, input int s);
    int d = r - s;
    if (d > MAXV) return MAXV;
    if (d < MINV) return MINV;
    return d;
  endfunction

  function automatic int model_sat(input int r, input int s);
    int d = r - s;
    return ((d > MAXV) || (d < MINV)) ? 1 : 0;
  endfunction

  // Integrator: FFD1 = Ki*ek, FFD2 = FFD1 + acc, FFD3 = FFD2, output loads on en2.
  int p1, p2, p3, acc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1 <= 0; p2 <= 0; p3 <= 0; acc <= 0;
    end else begin
      p1 <= KI * int'(ifc.ek);
      p2 <= p1 + acc;
      p3 <= p2;
      if (ifc.en2) acc <= p3;
    end
  end

  // Monitor on the falling edge: scoreboard pop on en1, ek stability, en2 count, acc timing.
  int ek_prev = 0, acc_prev = 0;
  logic en2_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      ek_prev = 0; acc_prev = 0; en2_prev = 1'b0;
    end else begin
      if (ifc.en1) begin
        if (exp_ek_q.size() == 0) chk("sb_unexpected_en1", 1, 0);
        else begin
          chk("sb_ek", int'(ifc.ek), exp_ek_q.pop_front());
          chk("sb_sat", 32'(ifc.sat_flag), exp_sat_q.pop_front());
        end
        chk("en1_en2_excl", 32'(ifc.en2), 0);
      end else begin
        chk("ek_stable", int'(ifc.ek), ek_prev);
      end
      if (ifc.en2) en2_cnt++;
      chk("acc_only_after_en2", ((acc != acc_prev) && !en2_prev) ? 1 : 0, 0);
      ek_prev = int'(ifc.ek); acc_prev = acc; en2_prev = ifc.en2;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int s);
    ifc.ref_in    = N'(r);
    ifc.sample_in = N'(s);
  endtask

  // Waits (bounded) for ready, presents one sample, returns in cycle c1.
  task automatic send(input int r, input int s);
    int n = 0;
    while (!ifc.sample_ready && n < 50) begin step(); n++; end
    chk("send_ready_timeout", (n < 50) ? 1 : 0, 1);
    drive(r, s);
    ifc.sample_valid = 1'b1;
    exp_ek_q.push_back(model_ek(r, s));
    exp_sat_q.push_back(model_sat(r, s));
    step();
    ifc.sample_valid = 1'b0;
  endtask

  initial begin
    int at[3];
    int k, cyc, e2, ea;
    ifc.ref_in = '0; ifc.sample_in = '0; ifc.sample_valid = 1'b0; ifc.hold = 1'b0;
    step(); step();
    chk("rst_ek", int'(ifc.ek), 0);
    chk("rst_en1", 32'(ifc.en1), 0);
    chk("rst_en2", 32'(ifc.en2), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_sat", 32'(ifc.sat_flag), 0);
    reset = 1'b1;
    step();
    chk("rst_ready", 32'(ifc.sample_ready), 1);

    // T1: basic sequence timing
    send(1000, 400);                                   // now in c1
    chk("t1_ek_c1", int'(ifc.ek), 600);
    chk("t1_en1_c1", 32'(ifc.en1), 1);
    chk("t1_busy_c1", 32'(ifc.busy), 1);
    chk("t1_ready_c1", 32'(ifc.sample_ready), 0);
    chk("t1_sat", 32'(ifc.sat_flag), 0);
    step();                                            // c2
    chk("t1_en1_c2", 32'(ifc.en1), 0);
    chk("t1_en2_c2", 32'(ifc.en2), 0);
    step();                                            // c3
    chk("t1_en2_c3", 32'(ifc.en2), 0);
    chk("t1_busy_c3", 32'(ifc.busy), 1);
    step();                                            // c4
    chk("t1_en2_c4", 32'(ifc.en2), 1);
    chk("t1_busy_c4", 32'(ifc.busy), 1);
    chk("t1_ready_c4", 32'(ifc.sample_ready), 0);
    step();                                            // c5
    chk("t1_en2_c5", 32'(ifc.en2), 0);
    chk("t1_busy_c5", 32'(ifc.busy), 0);
    chk("t1_ready_c5", 32'(ifc.sample_ready), 1);

    // T2: saturation corners
    send(131071, -131072);
    chk("t2_pos_ek", int'(ifc.ek), 131071);
    chk("t2_pos_sat", 32'(ifc.sat_flag), 1);
    repeat (LAT + 1) step();
    send(-131072, 1);
    chk("t2_neg_ek", int'(ifc.ek), -131072);
    chk("t2_neg_sat", 32'(ifc.sat_flag), 1);
    repeat (LAT + 1) step();
    send(-5, 3);
    chk("t2_mid_ek", int'(ifc.ek), -8);
    chk("t2_mid_sat", 32'(ifc.sat_flag), 0);
    repeat (LAT + 1) step();

    // T3: valid held high, three back-to-back samples
    e2 = en2_cnt;
    k = 0; cyc = 0;
    drive(10, 3);
    ifc.sample_valid = 1'b1;
    while (k < 3 && cyc < 40) begin
      if (ifc.sample_ready) begin
        at[k] = cyc;
        exp_ek_q.push_back(model_ek(int'(ifc.ref_in), int'(ifc.sample_in)));
        exp_sat_q.push_back(model_sat(int'(ifc.ref_in), int'(ifc.sample_in)));
        k++;
        step(); cyc++;
        if (k == 1) drive(20, -30);
        else if (k == 2) drive(-7, 8);
        else ifc.sample_valid = 1'b0;
      end else begin
        step(); cyc++;
      end
    end
    chk("t3_accepted", k, 3);
    chk("t3_gap1", at[1] - at[0], LAT + 2);
    chk("t3_gap2", at[2] - at[1], LAT + 2);
    repeat (LAT + 1) step();
    chk("t3_en2_count", en2_cnt - e2, 3);

    // T4: reset mid-sequence drops the update
    e2 = en2_cnt;
    send(300, 100);                                    // c1
    step();                                            // c2
    reset = 1'b0;
    #1;
    chk("t4_ek_rst", int'(ifc.ek), 0);
    chk("t4_busy_rst", 32'(ifc.busy), 0);
    chk("t4_en1_rst", 32'(ifc.en1), 0);
    step();                                            // c3
    reset = 1'b1;
    #1;
    chk("t4_ready_after", 32'(ifc.sample_ready), 1);
    repeat (4) step();
    chk("t4_no_en2", en2_cnt - e2, 0);
    chk("t4_busy_after", 32'(ifc.busy), 0);

    // T5: hold raised mid-sequence
    e2 = en2_cnt;
    send(50, 20);                                      // c1
    step();                                            // c2
    ifc.hold = 1'b1;
    drive(77, 1);
    ifc.sample_valid = 1'b1;
    step();                                            // c3
    chk("t5_en2_c3", 32'(ifc.en2), 0);
    step();                                            // c4
    chk("t5_en2_c4", 32'(ifc.en2), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_ready_held", 32'(ifc.sample_ready), 0);
      chk("t5_idle_held", 32'(ifc.busy), 0);
    end
    chk("t5_ek_frozen", int'(ifc.ek), 30);
    ifc.hold = 1'b0;
    #1;
    chk("t5_ready_release", 32'(ifc.sample_ready), 1);
    exp_ek_q.push_back(model_ek(77, 1));
    exp_sat_q.push_back(model_sat(77, 1));
    step();
    ifc.sample_valid = 1'b0;
    chk("t5_ek_new", int'(ifc.ek), 76);
    repeat (LAT + 1) step();
    chk("t5_en2_count", en2_cnt - e2, 2);

    // T6: integrator accumulation, cleared by a reset pulse first
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    ea = 0;
    for (int i = 1; i <= 4; i++) begin
      send(100, 90);                                   // c1
      repeat (LAT) step();                             // c4 (en2)
      chk("t6_acc_before", acc, ea);
      ea = ea + KI * 10;
      step();                                          // c5
      chk("t6_acc_after", acc, ea);
    end
    chk("t6_acc_final", acc, 4 * KI * 10);
    chk("sb_drained", exp_ek_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
